dig_stopwatch_axil_slave: RTL

//  AXI4-Lite responder for the digital stopwatch IP; the bus master (MicroBlaze or AXI VIP master) initiates every transfer.

---
 rtl/dig_stopwatch_pkg.sv | 40 ++++
 rtl/dig_stopwatch_axil_slave_if.sv | 37 +++
 rtl/dig_stopwatch_tick_gen.sv | 35 +++
 rtl/dig_stopwatch_axil_slave.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dig_stopwatch_pkg.sv
// Shared constants and types for the stopwatch AXI4-Lite slave and its timebase.
package dig_stopwatch_pkg;

  // Byte offsets of the four registers; only ADDR[3:2] is decoded
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PRESCALE = 4'h4;
  localparam logic [3:0] REG_COUNT    = 4'h8;
  localparam logic [3:0] REG_SCRATCH  = 4'hC;

  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [1:0]  AXI_RESP_OKAY        = 2'b00;
  localparam logic [31:0] PRESCALE_RST_DEFAULT = 32'd99_999;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACCEPT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  // Merge write data into a register image, one byte per strobe bit
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dig_stopwatch_axil_slave_if.sv
// AXI4-Lite bus bundle between the stopwatch slave and its master.
interface dig_stopwatch_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dig_stopwatch_tick_gen.sv
// Prescaled timebase: psc counts cycles, COUNT advances once per PRESCALE+1 cycles.
module dig_stopwatch_tick_gen
  import dig_stopwatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] prescale,
  output logic [31:0] count
);
  logic [31:0] psc;
  logic [31:0] count_q;
  logic        tick;

  // >= rather than == so that lowering PRESCALE below psc ticks immediately
  assign tick  = run && (psc >= prescale);
  assign count = count_q;

  // Clear wins over a simultaneous tick; RUN=0 freezes both counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      count_q <= '0;
    end else if (clear) begin
      psc     <= '0;
      count_q <= '0;
    end else if (tick) begin
      psc     <= '0;
      count_q <= count_q + 32'd1;
    end else if (run) begin
      psc     <= psc + 32'd1;
    end
  end
endmodule

// File: rtl/dig_stopwatch_axil_slave.sv
// AXI4-Lite slave for the stopwatch: CTRL/PRESCALE/COUNT/SCRATCH plus the timebase.
module dig_stopwatch_axil_slave
  import dig_stopwatch_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] PRESCALE_RST       = PRESCALE_RST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dig_stopwatch_axil_slave_if.slave bus,
  output logic [31:0]               count,
  output logic                      running
);
  wr_state_t wr_state;
  rd_state_t rd_state;

  logic awready_q, wready_q, bvalid_q;
  logic arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
  logic [C_S_AXI_DATA_WIDTH-1:0] prescale;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch;
  logic        ctrl_run;
  logic [3:0]  wr_off;
  logic [3:0]  rd_off;
  logic        wr_fire;
  logic        clr_req;
  logic [31:0] count_val;
  logic        unused_bits;

  assign wr_off  = {bus.awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2], 2'b00};
  assign rd_off  = {bus.araddr[C_S_AXI_ADDR_WIDTH-1 -: 2], 2'b00};
  // The acceptance cycle is exactly the W_ACCEPT state (AW/W held valid by the master)
  assign wr_fire = (wr_state == W_ACCEPT);
  assign clr_req = wr_fire && (wr_off == REG_CTRL) && bus.wstrb[0] && bus.wdata[CTRL_CLR_BIT];

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = AXI_RESP_OKAY;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = AXI_RESP_OKAY;

  assign count   = count_val;
  assign running = ctrl_run;

  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

  // Write channel: joint AW/W acceptance pulse, then hold B until the master takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (bus.awvalid && bus.wvalid) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= W_ACCEPT;
          end
        end
        W_ACCEPT: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          wr_state  <= W_RESP;
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          wr_state  <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel: one-cycle ARREADY, RDATA captured on that edge and held while RVALID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bus.arvalid) begin
            arready_q <= 1'b1;
            rd_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_mux;
          rd_state  <= R_DATA;
        end
        R_DATA: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rd_state  <= R_IDLE;
        end
      endcase
    end
  end

  // Register file updates on the write acceptance edge; COUNT writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_run <= 1'b0;
      prescale <= PRESCALE_RST;
      scratch  <= '0;
    end else if (wr_fire) begin
      case (wr_off)
        REG_CTRL:     if (bus.wstrb[0]) ctrl_run <= bus.wdata[CTRL_RUN_BIT];
        REG_PRESCALE: prescale <= apply_wstrb(prescale, bus.wdata, bus.wstrb);
        REG_SCRATCH:  scratch  <= apply_wstrb(scratch, bus.wdata, bus.wstrb);
        default: ;
      endcase
    end
  end

  // Read mux; CLR and the upper CTRL bits always read as zero
  always_comb begin
    rd_mux = '0;
    case (rd_off)
      REG_CTRL:     rd_mux[CTRL_RUN_BIT] = ctrl_run;
      REG_PRESCALE: rd_mux = prescale;
      REG_COUNT:    rd_mux = count_val;
      REG_SCRATCH:  rd_mux = scratch;
      default:      rd_mux = '0;
    endcase
  end

  dig_stopwatch_tick_gen u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (ctrl_run),
    .clear    (clr_req),
    .prescale (prescale),
    .count    (count_val)
  );
endmodule
